seq_detect_param: RTL and testbench

Parametrised serial pattern detector, successor to the fixed 6-bit group detector. Accepts one bit per valid cycle and compares it against a PAT_W-bit pattern set by parameter. Two run-time modes:
- Framed mode: non-overlapping groups of PAT_W bits, reports match or not_match per group.
- Sliding mode: overlapping window, reports every occurrence.

Sits on serial control/diagnostic streams ahead of framing logic. Uses a counter plus a small FSM instead of a one-hot state per bit.

---
 rtl/seq_detect_param.sv | 84 ++++++++
 tb/tb_seq_detect_param.sv | 107 ++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial PAT_W-bit pattern detector with framed (group) and sliding (window) modes.
// Define SEQ_DET_CNT_EN to add a saturating match counter (cnt_clr / match_cnt, width CNT_W).
module seq_detect_param #(
   parameter int PAT_W = 6,
   parameter logic [PAT_W-1:0] PATTERN = 6'b011100
`ifdef SEQ_DET_CNT_EN
   ,parameter int CNT_W = 8
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic data_valid,
   input  logic data,
   input  logic mode,
`ifdef SEQ_DET_CNT_EN
   input  logic cnt_clr,
   output logic [CNT_W-1:0] match_cnt,
`endif
   output logic match,
   output logic not_match,
   output logic busy
);
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SLIDE} state_t;
   localparam int CW = $clog2(PAT_W + 1);
   localparam logic [CW-1:0] LAST = CW'(PAT_W - 1);
   localparam logic [CW-1:0] FULL = CW'(PAT_W);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   // Only the PAT_W-1 older bits are stored; the incoming bit completes the window.
   logic [PAT_W-2:0] shift_q, shift_d;
   logic [PAT_W-1:0] window;
   logic mode_q, eval, match_d, not_match_d;
   logic match_q, not_match_q, busy_q;
   assign window = {shift_q, data};
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      shift_d = shift_q;
      eval = 1'b0;
      if (mode != mode_q) begin
         state_d = S_IDLE;
         cnt_d = '0;
         shift_d = '0;
      end else if (data_valid) begin
         shift_d = window[PAT_W-2:0];
         state_d = state_q == S_IDLE ? (mode ? S_SLIDE : S_COLLECT) : state_q;
         eval = state_q != S_IDLE && cnt_q >= LAST;
         cnt_d = (state_q == S_COLLECT && cnt_q == LAST) ? '0 :
                 (cnt_q == FULL) ? FULL : cnt_q + CW'(1);
      end
   end
   assign match_d = eval && window == PATTERN;
   assign not_match_d = eval && state_q == S_COLLECT && window != PATTERN;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         shift_q <= '0;
         mode_q <= 1'b0;
         match_q <= 1'b0;
         not_match_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         shift_q <= shift_d;
         mode_q <= mode;
         match_q <= match_d;
         not_match_q <= not_match_d;
         busy_q <= cnt_d != '0 && cnt_d < FULL;
      end
   end
   assign match = match_q;
   assign not_match = not_match_q;
   assign busy = busy_q;
`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] match_cnt_q;
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) match_cnt_q <= '0;
      else if (match_d && !(&match_cnt_q)) match_cnt_q <= match_cnt_q + CNT_W'(1);
   end
   assign match_cnt = match_cnt_q;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: vector-table bench for seq_detect_param (PAT_W=6, PATTERN=011100).
module tb_seq_detect_param;
   logic clk = 1'b0;
   logic rst = 1'b1, data_valid = 1'b0, data = 1'b0, mode = 1'b0;
   logic match, not_match, busy;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
`ifdef SEQ_DET_CNT_EN
   logic cnt_clr = 1'b0;
   logic [1:0] match_cnt;
   seq_detect_param #(.PAT_W(6), .PATTERN(6'b011100), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .mode(mode),
      .cnt_clr(cnt_clr), .match_cnt(match_cnt),
      .match(match), .not_match(not_match), .busy(busy));
`else
   seq_detect_param #(.PAT_W(6), .PATTERN(6'b011100)) dut (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .mode(mode),
      .match(match), .not_match(not_match), .busy(busy));
`endif
   typedef struct {
      logic r, v, d, m, em, en, eb;
      string n;
   } vec_t;
   vec_t vq[$];
   function automatic void add(logic r, logic v, logic d, logic m, logic em, logic en, logic eb, string n);
      vq.push_back('{r, v, d, m, em, en, eb, n});
   endfunction
   // Bit vectors are listed first-received bit in the MSB; masks give expected outputs after each bit.
   function automatic void grp(string n, logic m, logic [15:0] b, int len, logic [15:0] em, logic [15:0] en, logic [15:0] eb);
      for (int i = len - 1; i >= 0; i--) add(1'b0, 1'b1, b[i], m, em[i], en[i], eb[i], n);
   endfunction
   task automatic drive(logic r, logic v, logic d, logic m);
      @(negedge clk);
      rst = r; data_valid = v; data = d; mode = m;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", n, act, exp);
      end
   endtask
   int nm, nn;
   initial begin
      add(1, 0, 0, 0, 0, 0, 0, "rst");
      add(1, 1, 1, 0, 0, 0, 0, "rst");
      grp("t1", 0, 16'b011100, 6, 16'b000001, 16'b0, 16'b111110);
      add(0, 0, 0, 0, 0, 0, 0, "t1gap");
      grp("t2", 0, 16'b011101011100, 12, 16'b000000000001, 16'b000001000000, 16'b111110111110);
      grp("t3a", 0, 16'b011, 3, 16'b0, 16'b0, 16'b111);
      for (int i = 0; i < 3; i++) add(0, 0, 1'bx, 0, 0, 0, 1, "t3gap");
      grp("t3b", 0, 16'b100, 3, 16'b001, 16'b0, 16'b110);
      grp("t5a", 0, 16'b011, 3, 16'b0, 16'b0, 16'b111);
      add(1, 1, 1, 0, 0, 0, 0, "t5rst");
      grp("t5b", 0, 16'b011100, 6, 16'b000001, 16'b0, 16'b111110);
      grp("t5c", 0, 16'b011, 3, 16'b0, 16'b0, 16'b111);
      add(0, 1, 1, 1, 0, 0, 0, "t5mode1");
      add(0, 1, 0, 0, 0, 0, 0, "t5mode0");
      grp("t5d", 0, 16'b011100, 6, 16'b000001, 16'b0, 16'b111110);
      add(0, 1, 0, 1, 0, 0, 0, "t4mode");
      grp("t4", 1, 16'b01110011100, 11, 16'b00000100001, 16'b0, 16'b11111000000);
      add(0, 0, 0, 1, 0, 0, 0, "t4gap");
      add(0, 0, 0, 0, 0, 0, 0, "t7mode");
      drive(1, 0, 0, 0);
`ifdef SEQ_DET_CNT_EN
      chk("cnt_reset", match_cnt, 0);
`endif
      foreach (vq[i]) begin
         drive(vq[i].r, vq[i].v, vq[i].d, vq[i].m);
         chk($sformatf("%s[%0d].match", vq[i].n, i), match, vq[i].em);
         chk($sformatf("%s[%0d].not_match", vq[i].n, i), not_match, vq[i].en);
         chk($sformatf("%s[%0d].busy", vq[i].n, i), busy, vq[i].eb);
      end
      // Three back-to-back framed groups: wrap must not lose a cycle.
      nm = 0; nn = 0;
      for (int g = 0; g < 3; g++)
         for (int i = 5; i >= 0; i--) begin
            drive(0, 1, (6'b011100 >> i) & 1'b1, 0);
            nm += int'(match); nn += int'(not_match);
         end
      chk("b2b_matches", 8'(nm), 3);
      chk("b2b_not_matches", 8'(nn), 0);
      chk("b2b_busy", busy, 0);
`ifdef SEQ_DET_CNT_EN
      drive(0, 0, 0, 1);
      nm = 0;
      drive(0, 1, 0, 1);
      for (int k = 0; k < 5; k++)
         for (int i = 4; i >= 0; i--) begin
            drive(0, 1, (5'b11100 >> i) & 1'b1, 1);
            nm += int'(match);
         end
      chk("cnt_slide_matches", 8'(nm), 5);
      chk("cnt_saturated", match_cnt, 3);
      for (int i = 4; i >= 1; i--) drive(0, 1, (5'b11100 >> i) & 1'b1, 1);
      cnt_clr = 1'b1;
      drive(0, 1, 0, 1);
      cnt_clr = 1'b0;
      chk("clr_match", match, 1);
      chk("clr_wins", match_cnt, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
